ni_burst_ctrl: RTL and testbench

- Multi-cycle network-interface transfer controller for the MIPS pipeline.
- Successor to the single-word, combinational NI send/receive decode: adds parametrised node-address width, bursts of up to BURST_MAX words, and a valid/ready state machine that stalls decode until the burst completes.
- Sits beside the decode-stage control unit, which keeps driving all non-NI instructions; this block owns the NI handshake signals.

---
 rtl/ni_burst_ctrl_pkg.sv | 33 +++
 rtl/ni_burst_ctrl_if.sv | 40 ++++
 rtl/ni_burst_ctrl_timeout_ctr.sv | 32 +++
 rtl/ni_burst_ctrl.sv | 155 +++++++++++++++
 tb/tb_ni_burst_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ni_burst_ctrl_pkg.sv
// Shared definitions for the NI burst controller: NI opcodes (also used by
// the decode-stage control unit), FSM state encoding and a clog2 helper.
package ni_ctrl_pkg;

  localparam logic [5:0] NI_OUT = 6'b010101;
  localparam logic [5:0] NI_IN  = 6'b011010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } ni_state_e;

  // Ceiling log2, usable in parameter expressions
  function automatic int ni_clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  // Ceiling log2 but never below one bit, for field widths
  function automatic int ni_width(input int value);
    return (ni_clog2(value) < 1) ? 1 : ni_clog2(value);
  endfunction

endpackage

// File: rtl/ni_burst_ctrl_if.sv
// Bundle of decode-stage and NI handshake signals around the burst
// controller. The slave modport is the controller's view; the master
// modport is the surrounding pipeline/NI.
interface ni_burst_ctrl_if #(
  parameter int NODE_W = 2,
  parameter int LEN_W  = 2
);
  logic              instr_valid;
  logic [5:0]        opcode;
  logic [NODE_W-1:0] dest_field;
  logic [LEN_W-1:0]  len_field;
  logic              flush;
  logic [NODE_W-1:0] current_node;
  logic              mips_ni;
  logic              data_valid;
  logic [NODE_W-1:0] dest_add;
  logic              proc_valid;
  logic              proc_ready_in;
  logic              alu_out_sel;
  logic              reg_en;
  logic [LEN_W-1:0]  word_idx;
  logic              stall;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  instr_valid, opcode, dest_field, len_field, flush,
           current_node, mips_ni, data_valid,
    output dest_add, proc_valid, proc_ready_in, alu_out_sel, reg_en,
           word_idx, stall, busy, done, err
  );

  modport master (
    output instr_valid, opcode, dest_field, len_field, flush,
           current_node, mips_ni, data_valid,
    input  dest_add, proc_valid, proc_ready_in, alu_out_sel, reg_en,
           word_idx, stall, busy, done, err
  );
endinterface

// File: rtl/ni_burst_ctrl_timeout_ctr.sv
// Idle-handshake watchdog counter: clear has priority over increment,
// expire flags the terminal count CYC-1.
module ni_timeout_ctr
  import ni_ctrl_pkg::*;
#(
  parameter int CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int W = ni_width(CYC);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count idle cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == W'(CYC - 1));
endmodule

// File: rtl/ni_burst_ctrl.sv
// Multi-word NI send/receive controller with valid/ready handshake that
// stalls decode until a burst retires. Optional idle-handshake abort is
// enabled with the NI_TIMEOUT_EN macro.
module ni_burst_ctrl
  import ni_ctrl_pkg::*;
#(
  parameter int NODE_W      = 2,
  parameter int BURST_MAX   = 4,
  parameter int LEN_W       = ni_width(BURST_MAX),
  parameter int TIMEOUT_CYC = 256
) (
  input  logic           clk,
  input  logic           rst,
  ni_burst_ctrl_if.slave bus
);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(BURST_MAX - 1);

  ni_state_e         state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NODE_W-1:0] dest_q, dest_d;

  logic              is_ni_op;
  logic              accept;
  logic              in_burst;
  logic              xfer;
  logic [LEN_W-1:0]  len_eff;
  logic              timeout_hit;
  logic              abort_flag;

  assign is_ni_op = (bus.opcode == NI_OUT) || (bus.opcode == NI_IN);
  assign accept   = (state_q == S_IDLE) && bus.instr_valid && is_ni_op && !bus.flush;
  assign in_burst = (state_q == S_SEND) || (state_q == S_RECV);
  assign xfer     = ((state_q == S_SEND) && bus.mips_ni) ||
                    ((state_q == S_RECV) && bus.data_valid);
  assign len_eff  = (bus.len_field > LEN_MAX) ? LEN_MAX : bus.len_field;

`ifdef NI_TIMEOUT_EN
  logic to_expire;
  logic abort_q;

  ni_timeout_ctr #(.CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_burst || xfer),
    .inc_i    (in_burst && !xfer),
    .expire_o (to_expire)
  );

  assign timeout_hit = in_burst && to_expire && !xfer;

  // Remember that the DONE visit was caused by an abort, not completion
  always_ff @(posedge clk) begin
    if (rst) abort_q <= 1'b0;
    else     abort_q <= timeout_hit && !bus.flush;
  end

  assign abort_flag = abort_q;
`else
  assign timeout_hit = 1'b0;
  assign abort_flag  = 1'b0;
`endif

  // State, word counter and latched instruction fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      dest_q  <= dest_d;
    end
  end

  // Next state: flush beats both abort and the last-word transfer
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    dest_d  = dest_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          dest_d  = bus.dest_field;
          len_d   = len_eff;
          count_d = '0;
          state_d = (bus.opcode == NI_OUT) ? S_SEND : S_RECV;
        end
      end
      S_SEND, S_RECV: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          count_d = '0;
        end else if (xfer) begin
          if (count_q == len_q) begin
            state_d = S_DONE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs plus the combinational decode stall and reg_en
  always_comb begin
    bus.dest_add      = bus.current_node;
    bus.proc_valid    = 1'b0;
    bus.proc_ready_in = 1'b0;
    bus.alu_out_sel   = 1'b0;
    bus.reg_en        = 1'b0;
    bus.word_idx      = '0;
    bus.stall         = 1'b0;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.err           = 1'b0;
    unique case (state_q)
      S_IDLE: bus.stall = accept && !rst;
      S_SEND: begin
        bus.proc_valid  = 1'b1;
        bus.alu_out_sel = 1'b1;
        bus.dest_add    = dest_q;
        bus.word_idx    = count_q;
        bus.stall       = !rst;
        bus.busy        = 1'b1;
      end
      S_RECV: begin
        bus.proc_ready_in = 1'b1;
        bus.reg_en        = bus.data_valid;
        bus.word_idx      = count_q;
        bus.stall         = !rst;
        bus.busy          = 1'b1;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = !abort_flag;
        bus.err  = abort_flag;
      end
      default: bus.stall = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_ni_burst_ctrl.sv
// Directed self-checking bench for ni_burst_ctrl. Define NI_TIMEOUT_EN to
// also exercise the idle-handshake abort with TIMEOUT_CYC=8.
module tb_ni_burst_ctrl;
  import ni_ctrl_pkg::*;

  localparam int NODE_W      = 2;
  localparam int BURST_MAX   = 4;
  localparam int LEN_W       = 2;
  localparam int TIMEOUT_CYC = 8;

  // Flag vector order: proc_valid, proc_ready_in, alu_out_sel, reg_en,
  // stall, busy, done, err
  localparam logic [7:0] F_IDLE  = 8'h00;
  localparam logic [7:0] F_DEC   = 8'h08;
  localparam logic [7:0] F_SEND  = 8'hAC;
  localparam logic [7:0] F_RECV  = 8'h4C;
  localparam logic [7:0] F_RECVD = 8'h5C;
  localparam logic [7:0] F_RRST  = 8'h44;
  localparam logic [7:0] F_DONE  = 8'h06;
  localparam logic [7:0] F_ERR   = 8'h05;

  logic clk = 1'b0;
  logic rst;
  int   testCount   = 0;
  int   failCount   = 0;
  int   regEnCount  = 0;
  int   doneCount   = 0;
  int   errCount    = 0;
  int   base;

  always #5 clk = ~clk;

  ni_burst_ctrl_if #(.NODE_W(NODE_W), .LEN_W(LEN_W)) bus ();

  ni_burst_ctrl #(
    .NODE_W      (NODE_W),
    .BURST_MAX   (BURST_MAX),
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Tally pulse outputs mid-cycle for handshake-count checks
  always @(negedge clk) begin
    if (bus.reg_en === 1'b1) regEnCount++;
    if (bus.done === 1'b1)   doneCount++;
    if (bus.err === 1'b1)    errCount++;
  end

  function automatic logic [7:0] flagsNow();
    return {bus.proc_valid, bus.proc_ready_in, bus.alu_out_sel, bus.reg_en,
            bus.stall, bus.busy, bus.done, bus.err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [5:0] op,
                               input logic [1:0] dst, input logic [1:0] len,
                               input logic fl, input logic mni, input logic dv);
    bus.instr_valid = iv;
    bus.opcode      = op;
    bus.dest_field  = dst;
    bus.len_field   = len;
    bus.flush       = fl;
    bus.mips_ni     = mni;
    bus.data_valid  = dv;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] flags,
                          input logic [1:0] dst, input logic [1:0] idx);
    checkOutput({tag, "/flags"}, 32'(flagsNow()), 32'(flags));
    checkOutput({tag, "/dest"},  32'(bus.dest_add), 32'(dst));
    checkOutput({tag, "/idx"},   32'(bus.word_idx), 32'(idx));
  endtask

  initial begin
    // Reset: NI decode presented while rst high must not stall
    rst = 1'b1;
    bus.current_node = 2'd1;
    applyStimulus(1'b1, NI_OUT, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("reset", F_IDLE, 2'd1, 2'd0);
    bus.current_node = 2'd0;
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkAll("idle", F_IDLE, 2'd0, 2'd0);

    // Non-NI instruction is left to the control unit
    applyStimulus(1'b1, 6'b000000, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0);
    checkAll("non_ni", F_IDLE, 2'd0, 2'd0);
    tick();
    checkAll("non_ni_after", F_IDLE, 2'd0, 2'd0);

    // Send 3 words to node 2, NI not ready for the first two cycles
    base = doneCount;
    applyStimulus(1'b1, NI_OUT, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    checkAll("send_dec", F_DEC, 2'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkAll("send_wait0", F_SEND, 2'd2, 2'd0);
    tick();
    checkAll("send_wait1", F_SEND, 2'd2, 2'd0);
    bus.mips_ni = 1'b1;
    #1;
    checkAll("send_w0", F_SEND, 2'd2, 2'd0);
    tick();
    checkAll("send_w1", F_SEND, 2'd2, 2'd1);
    tick();
    checkAll("send_w2", F_SEND, 2'd2, 2'd2);
    tick();
    bus.mips_ni = 1'b0;
    #1;
    checkAll("send_done", F_DONE, 2'd0, 2'd0);
    tick();
    checkAll("send_idle", F_IDLE, 2'd0, 2'd0);
    checkOutput("send_done_cnt", 32'(doneCount - base), 32'd1);

    // Receive 2 words with gaps in data_valid
    base = regEnCount;
    applyStimulus(1'b1, NI_IN, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    checkAll("recv_dec", F_DEC, 2'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkAll("recv_gap0", F_RECV, 2'd0, 2'd0);
    tick();
    bus.data_valid = 1'b1;
    #1;
    checkAll("recv_w0", F_RECVD, 2'd0, 2'd0);
    tick();
    bus.data_valid = 1'b0;
    #1;
    checkAll("recv_gap1", F_RECV, 2'd0, 2'd1);
    tick();
    checkAll("recv_gap2", F_RECV, 2'd0, 2'd1);
    bus.data_valid = 1'b1;
    #1;
    checkAll("recv_w1", F_RECVD, 2'd0, 2'd1);
    tick();
    bus.data_valid = 1'b0;
    #1;
    checkAll("recv_done", F_DONE, 2'd0, 2'd0);
    tick();
    checkAll("recv_idle", F_IDLE, 2'd0, 2'd0);
    checkOutput("recv_regen_cnt", 32'(regEnCount - base), 32'd2);

    // Flush mid-burst, then flush priority over the last-word transfer
    base = doneCount;
    applyStimulus(1'b1, NI_OUT, 2'd1, 2'd3, 1'b1, 1'b1, 1'b0);
    checkAll("flush_in_idle", F_IDLE, 2'd0, 2'd0);
    bus.flush = 1'b0;
    #1;
    checkAll("flush_dec", F_DEC, 2'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    checkAll("flush_w0", F_SEND, 2'd1, 2'd0);
    tick();
    bus.flush = 1'b1;
    #1;
    checkAll("flush_cycle", F_SEND, 2'd1, 2'd1);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkAll("flush_idle", F_IDLE, 2'd0, 2'd0);
    applyStimulus(1'b1, NI_OUT, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    checkAll("flush_redec", F_DEC, 2'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkAll("flush_restart", F_SEND, 2'd3, 2'd0);
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    checkAll("flush_last", F_SEND, 2'd3, 2'd0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkAll("flush_prio", F_IDLE, 2'd0, 2'd0);
    checkOutput("flush_done_cnt", 32'(doneCount - base), 32'd0);

    // Reset during a receive burst
    applyStimulus(1'b1, NI_IN, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    checkAll("rst_w0", F_RECVD, 2'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkAll("rst_assert", F_RRST, 2'd0, 2'd1);
    tick();
    checkAll("rst_after", F_IDLE, 2'd0, 2'd0);
    rst = 1'b0;
    tick();
    checkAll("rst_release", F_IDLE, 2'd0, 2'd0);

    // Back-to-back sends with NI always ready
    base = doneCount;
    applyStimulus(1'b1, NI_OUT, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
    checkAll("b2b_dec1", F_DEC, 2'd0, 2'd0);
    tick();
    checkAll("b2b_s1", F_SEND, 2'd1, 2'd0);
    tick();
    applyStimulus(1'b1, NI_OUT, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0);
    checkAll("b2b_done1", F_DONE, 2'd0, 2'd0);
    tick();
    checkAll("b2b_dec2", F_DEC, 2'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    checkAll("b2b_s2w0", F_SEND, 2'd2, 2'd0);
    tick();
    checkAll("b2b_s2w1", F_SEND, 2'd2, 2'd1);
    tick();
    checkAll("b2b_done2", F_DONE, 2'd0, 2'd0);
    tick();
    checkAll("b2b_idle", F_IDLE, 2'd0, 2'd0);
    checkOutput("b2b_done_cnt", 32'(doneCount - base), 32'd2);

    // Loopback to own node is sent normally
    bus.current_node = 2'd2;
    applyStimulus(1'b1, NI_OUT, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    checkAll("loop_send", F_SEND, 2'd2, 2'd0);
    tick();
    checkAll("loop_done", F_DONE, 2'd2, 2'd0);
    tick();
    bus.current_node = 2'd0;

`ifdef NI_TIMEOUT_EN
    // Idle handshake abort after TIMEOUT_CYC send cycles
    base = errCount;
    applyStimulus(1'b1, NI_OUT, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      checkAll($sformatf("to_send%0d", i), F_SEND, 2'd1, 2'd0);
      tick();
    end
    checkAll("to_err", F_ERR, 2'd0, 2'd0);
    tick();
    checkAll("to_idle", F_IDLE, 2'd0, 2'd0);
    checkOutput("to_err_cnt", 32'(errCount - base), 32'd1);
`else
    checkOutput("err_never", 32'(errCount), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
